// File: rtl/rr_mux_arb8.sv
// Round-robin arbiter for eight requesters feeding one shared 8-to-1 data mux.
// One word is captured per grant and held in the output register until the consumer takes it.
module rr_mux_arb8 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   req,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic [W-1:0] i4,
    input  logic [W-1:0] i5,
    input  logic [W-1:0] i6,
    input  logic [W-1:0] i7,
    output logic [7:0]   gnt,
    output logic [2:0]   s,
    output logic [W-1:0] o,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         state_dbg
);

    // Output handshake: o is transferred on any rising edge where o_valid and
    // o_ready are both high; o, s and o_valid hold steady until that edge.

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state;
    logic [2:0]     ptr;
    logic [2:0]     winner;
    logic [2:0]     idx;
    logic           found;
    logic [W-1:0]   din [8];

    assign din[0] = i0;
    assign din[1] = i1;
    assign din[2] = i2;
    assign din[3] = i3;
    assign din[4] = i4;
    assign din[5] = i5;
    assign din[6] = i6;
    assign din[7] = i7;

    assign state_dbg = state;

    // Scan req starting at ptr; the 3-bit add wraps 7 back to 0.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            s       <= '0;
            o       <= '0;
            o_valid <= 1'b0;
            gnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        s       <= winner;
                        o       <= din[winner];
                        o_valid <= 1'b1;
                        gnt     <= 8'(1) << winner;
                        state   <= HOLD;
                    end else begin
                        o_valid <= 1'b0;
                        gnt     <= '0;
                    end
                end
                HOLD: begin
                    gnt <= '0;
                    // Priority only advances once the word has actually been taken.
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        ptr     <= s + 3'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rr_mux_arb8.md
RR_MUX_ARB8 -- requirements
Module: rr_mux_arb8

Interface
REQ-001 Parameter W SHALL default to 2 and set the data width of every data input and of the output register.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 req  input  8  SHALL carry the request lines; bit k set means requester k has valid data on ik.
REQ-005 i0..i7  input  W each  SHALL carry the requester data words.
REQ-006 gnt  output  8  SHALL be a registered one-hot acknowledge; bit k pulses when ik has been captured.
REQ-007 s  output  3  SHALL be the registered select of the current or last grant, suitable for driving the shared 8-to-1 mux select.
REQ-008 o  output  W  SHALL be the registered output data word.
REQ-009 o_valid  output  1  SHALL indicate that o holds a word not yet accepted.
REQ-010 o_ready  input  1  SHALL indicate that the consumer accepts o this cycle.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and HOLD.
REQ-012 The block SHALL keep a 3-bit round-robin pointer ptr (highest priority index).
REQ-013 In IDLE with req != 0, the block SHALL select the first set req bit scanning ptr, ptr+1, ... ptr+7 (mod 8), combinationally within the cycle.
REQ-014 On that edge the block SHALL load s <= winner, o <= i[winner], o_valid <= 1, gnt <= one-hot(winner), and go to HOLD.
REQ-015 In IDLE with req == 0, the block SHALL hold s, o and ptr, and SHALL drive o_valid = 0 and gnt = 0.
REQ-016 gnt SHALL be high for exactly one cycle (the first HOLD cycle) per grant and SHALL be 0 in every other cycle.
REQ-017 In HOLD, o, s and o_valid SHALL stay stable until o_valid & o_ready.
REQ-018 In HOLD, req changes SHALL be ignored.
REQ-019 On the handshake edge in HOLD, the block SHALL set o_valid <= 0 and ptr <= s+1 mod 8 (7 wraps to 0), and SHALL return to IDLE.
REQ-020 Grant-to-grant spacing SHALL be at least 2 cycles (one IDLE arbitration cycle after each handshake).
REQ-021 Requester k SHALL drop req[k] (or present new data) in the cycle after gnt[k]; a req still high at the next IDLE SHALL be treated as a new request.
REQ-022 A handshake in the same cycle as gnt (o_ready already high) SHALL complete normally, giving a 2-cycle grant period.
REQ-023 Under continuous full request, each requester SHALL be granted exactly once per 8 grants (starvation-free).
REQ-024 ptr SHALL update only on a handshake, never on arbitration alone.

Reset
REQ-025 While rst is high, the block SHALL asynchronously force state=IDLE, ptr=0, s=0, o=0, o_valid=0 and gnt=0.
REQ-026 A rst assertion in HOLD SHALL discard the held word without any handshake.
REQ-027 After rst deasserts, the block SHALL arbitrate on the first rising edge.

Verification
REQ-028 The bench SHALL cover: W=2, rst released, req=8'h00 for 5 cycles -> o_valid=0, gnt=0, s=0 throughout.
REQ-029 The bench SHALL cover: req=8'hFF, o_ready=1, ik=k[1:0] held 16 cycles -> gnt sequence 01,02,04,...,80,01 every 2 cycles; o follows s[1:0]; s wraps 7->0.
REQ-030 The bench SHALL cover: req=8'h24 with ptr=0, o_ready=0 for 4 cycles then 1 -> s=2, gnt=04 one cycle, o stable 5 cycles; next grant is s=5.
REQ-031 The bench SHALL cover: req[3] asserted in HOLD of a grant to 1 -> no effect until IDLE; then s=3 is granted.
REQ-032 The bench SHALL cover: rst pulsed mid-HOLD (o_valid=1, s=6) -> o_valid, gnt, s and o drop to 0 asynchronously; the next grant starts scanning from 0.
REQ-033 The bench SHALL cover: random req/o_ready for 10k cycles -> gnt always one-hot or zero; o stable while o_valid & !o_ready; no requester waits more than 8 grants.
